// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    // Fetch controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // An all-zero word stops the fetch stream
    localparam logic [31:0] HALT_INSTR = 32'h0000_0000;

    // Byte distance between consecutive instruction words
    localparam logic [31:0] PC_STEP = 32'd4;

    // One fetch queue entry: byte PC and the word found there
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO holding fetched {pc, instr} pairs.
// Flush wins over push and pop. The head reads straight from register storage.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push, do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    // A pop frees a slot in the same cycle, so a full FIFO may still accept a push
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointer advance, wrapping explicitly at DEPTH
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointers and occupancy; flush discards everything, including a same-cycle pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
            else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
        end
    end

    // Entry storage; contents need no reset because occupancy gates visibility
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_push && !flush && (wr_ptr_reg == PTR_W'(gi)))
                    mem[gi] <= din;
            end
        end
    endgenerate

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads a combinational instruction memory,
// queues {pc, instr} pairs and hands them to decode with valid/ready.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MEM_WORDS  = 256,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] Endereco,
    input  logic [31:0] Instrucao,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted,
    output logic        fault
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_t     state_reg, state_next;
    logic [31:0]      pc_reg, pc_next;
    logic             fault_reg, fault_next;
    logic             push, flush, pop, push_ok, out_of_range;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty, fifo_full;
    fetch_entry_t     push_entry, head_entry;
    logic             unused_bits;

    assign Endereco     = {2'b00, pc_reg[31:2]};
    assign out_of_range = (Endereco >= 32'(MEM_WORDS));
    assign pop          = out_valid & out_ready;
    assign push_ok      = (fifo_count < CNT_W'(FIFO_DEPTH)) | pop;
    assign push_entry   = '{pc: pc_reg, instr: Instrucao};
    assign unused_bits  = &{1'b0, redirect_pc[1:0], fifo_full};

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (push_entry),
        .head  (head_entry),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Outputs come from FIFO storage only, masked to zero while empty
    assign out_valid = ~fifo_empty;
    assign out_instr = fifo_empty ? 32'h0 : head_entry.instr;
    assign out_pc    = fifo_empty ? 32'h0 : head_entry.pc;
    assign halted    = (state_reg == HALTED);
    assign fault     = fault_reg;

    // Controller state, PC and sticky fault registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            fault_reg <= fault_next;
        end
    end

    // Next state and fetch decision: redirect > range fault > halt word > push > stall
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        fault_next = fault_reg;
        push       = 1'b0;
        flush      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                    pc_next    = RESET_PC;
                end
            end
            FETCH: begin
                if (redirect) begin
                    flush   = 1'b1;
                    pc_next = {redirect_pc[31:2], 2'b00};
                end else if (out_of_range) begin
                    fault_next = 1'b1;
                    state_next = HALTED;
                end else if (Instrucao == HALT_INSTR) begin
                    state_next = HALTED;
                end else if (push_ok) begin
                    push    = 1'b1;
                    pc_next = pc_reg + PC_STEP;
                end
            end
            HALTED: begin
                if (start) begin
                    state_next = FETCH;
                    pc_next    = RESET_PC;
                    flush      = 1'b1;
                    fault_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: program run, backpressure,
// redirect, out-of-range fault, asynchronous reset mid-stream.
module tb_instruction_fetch_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // DUT A: full 256-word memory holding the default program
    logic        start_a, redirect_a, out_ready_a;
    logic [31:0] redirect_pc_a, endereco_a, instrucao_a, out_instr_a, out_pc_a;
    logic        out_valid_a, halted_a, fault_a;

    // DUT B: 4-word memory with no halt word, for the range fault
    logic        start_b, out_ready_b;
    logic [31:0] endereco_b, instrucao_b, out_instr_b, out_pc_b;
    logic        out_valid_b, halted_b, fault_b;

    logic [31:0] prog [0:8];
    int checks = 0;
    int errors = 0;

    initial begin
        prog[0] = 32'h00B00393; prog[1] = 32'h00500413; prog[2] = 32'h008384B3;
        prog[3] = 32'h40838533; prog[4] = 32'h0073F5B3; prog[5] = 32'h00A4E633;
        prog[6] = 32'h00C02023; prog[7] = 32'h001100E3; prog[8] = 32'h00000000;
    end

    // Combinational instruction memories
    assign instrucao_a = (endereco_a < 32'd9) ? prog[endereco_a[3:0]] : 32'h0;
    assign instrucao_b = 32'hA000_0000 | endereco_b;

    instruction_fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(256), .FIFO_DEPTH(2)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .Endereco(endereco_a),
        .Instrucao(instrucao_a), .redirect(redirect_a), .redirect_pc(redirect_pc_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_instr(out_instr_a),
        .out_pc(out_pc_a), .halted(halted_a), .fault(fault_a)
    );

    instruction_fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(4), .FIFO_DEPTH(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .Endereco(endereco_b),
        .Instrucao(instrucao_b), .redirect(1'b0), .redirect_pc(32'h0),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_instr(out_instr_b),
        .out_pc(out_pc_b), .halted(halted_b), .fault(fault_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
    endtask

    // Consume DUT A's stream with out_ready=1, expecting program words from first_idx
    task automatic drain_a(input int first_idx);
        int idx = first_idx;
        for (int c = 0; c < 40 && !(halted_a && !out_valid_a); c++) begin
            if (out_valid_a) begin
                $display("accept pc=%h instr=%h", out_pc_a, out_instr_a);
                check("run_pc", out_pc_a, 32'(idx * 4));
                check("run_instr", out_instr_a, prog[idx[3:0]]);
                idx++;
            end
            step();
        end
        check("run_count", 32'(idx), 32'd8);
        check("run_halted", {31'b0, halted_a}, 32'd1);
        check("run_valid", {31'b0, out_valid_a}, 32'd0);
        check("run_fault", {31'b0, fault_a}, 32'd0);
    endtask

    initial begin
        int idx;
        int guard;
        start_a = 0; start_b = 0; redirect_a = 0; redirect_pc_a = 0;
        out_ready_a = 0; out_ready_b = 0;
        reset = 1'b1;
        #2;
        // Reset state, visible while reset is held
        check("rst_valid", {31'b0, out_valid_a}, 32'd0);
        check("rst_instr", out_instr_a, 32'd0);
        check("rst_pc", out_pc_a, 32'd0);
        check("rst_halted", {31'b0, halted_a}, 32'd0);
        check("rst_fault", {31'b0, fault_a}, 32'd0);
        check("rst_addr", endereco_a, 32'd0);
        step();
        reset = 1'b0;

        // Program run at full rate
        out_ready_a = 1'b1;
        pulse_start_a();
        drain_a(0);

        // Backpressure: queue fills with pc 0 and 4, fetch stalls at word 2
        do_reset();
        out_ready_a = 1'b0;
        pulse_start_a();
        repeat (5) step();
        check("bp_valid", {31'b0, out_valid_a}, 32'd1);
        check("bp_head_pc", out_pc_a, 32'd0);
        check("bp_addr", endereco_a, 32'd2);
        // Full FIFO with simultaneous push/pop: pc advances every cycle
        out_ready_a = 1'b1;
        step();
        check("fp_addr1", endereco_a, 32'd3);
        check("fp_pc1", out_pc_a, 32'd4);
        step();
        check("fp_addr2", endereco_a, 32'd4);
        check("fp_pc2", out_pc_a, 32'd8);
        drain_a(2);

        // Redirect while pc 8 is at the head
        do_reset();
        out_ready_a = 1'b1;
        pulse_start_a();
        guard = 0;
        while (!(out_valid_a && out_pc_a == 32'd8) && guard < 20) begin
            step();
            guard++;
        end
        check("rd_reach8", out_pc_a, 32'd8);
        redirect_a = 1'b1;
        redirect_pc_a = 32'h0000_0016;
        step();
        redirect_a = 1'b0;
        check("rd_flush", {31'b0, out_valid_a}, 32'd0);
        step();
        check("rd_pc20", out_pc_a, 32'd20);
        check("rd_instr20", out_instr_a, prog[5]);
        step();
        check("rd_pc24", out_pc_a, 32'd24);
        check("rd_instr24", out_instr_a, prog[6]);
        out_ready_a = 1'b0;

        // Out-of-range fetch on the 4-word DUT
        do_reset();
        out_ready_b = 1'b1;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        idx = 0;
        for (int c = 0; c < 30 && !(halted_b && !out_valid_b); c++) begin
            if (out_valid_b) begin
                $display("accept_b pc=%h instr=%h", out_pc_b, out_instr_b);
                check("oor_pc", out_pc_b, 32'(idx * 4));
                check("oor_instr", out_instr_b, 32'hA000_0000 | 32'(idx));
                idx++;
            end
            step();
        end
        check("oor_count", 32'(idx), 32'd4);
        check("oor_fault", {31'b0, fault_b}, 32'd1);
        check("oor_halted", {31'b0, halted_b}, 32'd1);
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        check("oor_restart_fault", {31'b0, fault_b}, 32'd0);
        check("oor_restart_halted", {31'b0, halted_b}, 32'd0);
        check("oor_restart_addr", endereco_b, 32'd0);
        step();
        check("oor_restart_pc", out_pc_b, 32'd0);
        check("oor_restart_valid", {31'b0, out_valid_b}, 32'd1);
        out_ready_b = 1'b0;

        // Asynchronous reset between edges with two entries queued
        do_reset();
        out_ready_a = 1'b0;
        pulse_start_a();
        repeat (3) step();
        check("mr_pre_valid", {31'b0, out_valid_a}, 32'd1);
        check("mr_pre_addr", endereco_a, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("mr_valid", {31'b0, out_valid_a}, 32'd0);
        check("mr_instr", out_instr_a, 32'd0);
        check("mr_pc", out_pc_a, 32'd0);
        check("mr_halted", {31'b0, halted_a}, 32'd0);
        check("mr_addr", endereco_a, 32'd0);
        step();
        reset = 1'b0;
        repeat (3) step();
        check("mr_idle_valid", {31'b0, out_valid_a}, 32'd0);
        check("mr_idle_addr", endereco_a, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
